// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead add/sub/adc/sbb with a valid/ready handshake on both sides.
// Optional saturation on signed overflow when PIPE_ADDSUB_SAT_EN is defined.
module pipelined_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
`ifdef PIPE_ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / GROUP;

  // One slice: per-bit g/p, group G/P, lookahead across groups, then bit carries inside each group.
  function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                            input logic ci);
    logic [SW-1:0] g, p, c_bit;
    logic [NG:0]   gc;
    logic          gg, gp, c;
    g     = x & y;
    p     = x | y;
    gc    = '0;
    c_bit = '0;
    gc[0] = ci;
    for (int j = 0; j < NG; j++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
        gp = gp & p[j*GROUP+i];
      end
      gc[j+1] = gg | (gp & gc[j]);
    end
    for (int j = 0; j < NG; j++) begin
      c = gc[j];
      for (int i = 0; i < GROUP; i++) begin
        c_bit[j*GROUP+i] = c;
        c = g[j*GROUP+i] | (p[j*GROUP+i] & c);
      end
    end
    return {gc[NG], x ^ y ^ c_bit};
  endfunction

  logic             en;
  logic [WIDTH-1:0] bp_in;
  logic             c0;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign bp_in    = op[0] ? ~b : b;
  assign c0       = op[1] ? cin : op[0];

  // Stage k register holds the sum bits finished so far plus skewed operands for later slices.
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  bp_q [STAGES];
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic              c_q  [STAGES];
  logic [STAGES-1:0] v_q;

  logic [WIDTH-1:0]  a_i  [STAGES];
  logic [WIDTH-1:0]  bp_i [STAGES];
  logic [WIDTH-1:0]  s_i  [STAGES];
  logic              c_i  [STAGES];
  logic [STAGES-1:0] v_i;
  logic [SW:0]       slice_r [STAGES];
  logic [WIDTH-1:0]  s_nx [STAGES];
  logic              c_nx [STAGES];
`ifdef PIPE_ADDSUB_SAT_EN
  logic              sat_q [STAGES];
  logic              sat_i [STAGES];
`endif

  always_comb begin
    a_i[0]  = a;
    bp_i[0] = bp_in;
    s_i[0]  = '0;
    c_i[0]  = c0;
    v_i[0]  = in_valid;
`ifdef PIPE_ADDSUB_SAT_EN
    sat_i[0] = sat;
`endif
    for (int k = 1; k < STAGES; k++) begin
      a_i[k]  = a_q[k-1];
      bp_i[k] = bp_q[k-1];
      s_i[k]  = s_q[k-1];
      c_i[k]  = c_q[k-1];
      v_i[k]  = v_q[k-1];
`ifdef PIPE_ADDSUB_SAT_EN
      sat_i[k] = sat_q[k-1];
`endif
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slice_r[k]           = cla_slice(a_i[k][k*SW +: SW], bp_i[k][k*SW +: SW], c_i[k]);
      s_nx[k]              = s_i[k];
      s_nx[k][k*SW +: SW]  = slice_r[k][SW-1:0];
      c_nx[k]              = slice_r[k][SW];
    end
  end

  // Flags come from the full result leaving the final slice; the carry into the MSB is recovered
  // from the MSB sum bit and its operands.
  logic [WIDTH-1:0] fin_sum, res_sum;
  logic             fin_cmsb, fin_ovf;

  assign fin_sum  = s_nx[STAGES-1];
  assign fin_cmsb = fin_sum[WIDTH-1] ^ a_i[STAGES-1][WIDTH-1] ^ bp_i[STAGES-1][WIDTH-1];
  assign fin_ovf  = fin_cmsb ^ c_nx[STAGES-1];

`ifdef PIPE_ADDSUB_SAT_EN
  // NOTE: every combinational output gets a default before the conditional, so no latch is inferred.
  always_comb begin
    res_sum = fin_sum;
    if (sat_i[STAGES-1] && fin_ovf)
      res_sum = a_i[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign res_sum = fin_sum;
`endif

  // NOTE: operand/partial-sum registers carry no reset; only valid bits and visible outputs need one.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= a_i[k];
        bp_q[k] <= bp_i[k];
        s_q[k]  <= s_nx[k];
        c_q[k]  <= c_nx[k];
`ifdef PIPE_ADDSUB_SAT_EN
        sat_q[k] <= sat_i[k];
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages advance on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (en) begin
      v_q  <= v_i;
      sum  <= res_sum;
      cout <= c_nx[STAGES-1];
      ovf  <= fin_ovf;
      zero <= ~|res_sum;
    end
  end

  assign out_valid = v_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub: vector table, stall/reset sequences, random traffic
// against a scoreboard, plus STAGES=1/4 instances for latency. Saturation cases need PIPE_ADDSUB_SAT_EN.
module tb_pipelined_cla_addsub;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sat;
    exp_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, cin;
  logic [31:0] a, b;
  logic [1:0]  op;
`ifdef PIPE_ADDSUB_SAT_EN
  logic        sat;
`endif
  logic        in_ready, out_valid, cout, ovf, zero;
  logic [31:0] sum;
  logic        u1_in_ready, u1_out_valid, u1_cout, u1_ovf, u1_zero;
  logic [31:0] u1_sum;
  logic        u4_in_ready, u4_out_valid, u4_cout, u4_ovf, u4_zero;
  logic [31:0] u4_sum;
  logic        one = 1'b1;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   nres = 0;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(32), .STAGES(2), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op), .cin(cin),
`ifdef PIPE_ADDSUB_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));

  pipelined_cla_addsub #(.WIDTH(32), .STAGES(1), .GROUP(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u1_in_ready), .a(a), .b(b), .op(op), .cin(cin),
`ifdef PIPE_ADDSUB_SAT_EN
    .sat(sat),
`endif
    .out_valid(u1_out_valid), .out_ready(one), .sum(u1_sum), .cout(u1_cout), .ovf(u1_ovf), .zero(u1_zero));

  pipelined_cla_addsub #(.WIDTH(32), .STAGES(4), .GROUP(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u4_in_ready), .a(a), .b(b), .op(op), .cin(cin),
`ifdef PIPE_ADDSUB_SAT_EN
    .sat(sat),
`endif
    .out_valid(u4_out_valid), .out_ready(one), .sum(u4_sum), .cout(u4_cout), .ovf(u4_ovf), .zero(u4_zero));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference arithmetic done with a 33-bit add, independent of any lookahead structure.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic s);
    logic [31:0] yp;
    logic [32:0] t;
    exp_t        e;
    yp     = o[0] ? ~y : y;
    t      = {1'b0, x} + {1'b0, yp} + {32'd0, (o[1] ? ci : o[0])};
    e.sum  = t[31:0];
    e.cout = t[32];
    e.ovf  = (x[31] == yp[31]) && (t[31] != x[31]);
    if (s && e.ovf) e.sum = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    e.zero = (e.sum == 32'd0);
    return e;
  endfunction

  function automatic vec_t mk(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                              input logic ci, input logic s, input logic [31:0] es,
                              input logic ec, input logic eo, input logic ez);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.cin = ci; v.sat = s;
    v.exp.sum = es; v.exp.cout = ec; v.exp.ovf = eo; v.exp.zero = ez;
    return v;
  endfunction

  // Drive one beat and hold it until accepted; the expectation is queued at the acceptance edge.
  task automatic send(input vec_t v, input string tag);
    bit acc;
    acc = 1'b0;
    op = v.op; a = v.a; b = v.b; cin = v.cin;
`ifdef PIPE_ADDSUB_SAT_EN
    sat = v.sat;
`endif
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        acc = 1'b1;
        sbq.push_back(v.exp);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check({tag, "_accepted"}, acc, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sbq.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_empty", sbq.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) sbq.delete();
    else if (out_valid && out_ready) begin
      check("beat_was_expected", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check($sformatf("result_%0d", nres), {sum, cout, ovf, zero}, e);
        nres++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t tbl[14];
  vec_t vr;
  int   lat1, lat2, lat4;
  logic [34:0] res1, res4;
  exp_t eadc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0; cin = 1'b0;
`ifdef PIPE_ADDSUB_SAT_EN
    sat = 1'b0;
`endif
    tbl[0]  = mk(2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    tbl[1]  = mk(2'd1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    tbl[2]  = mk(2'd2, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(2'd3, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(2'd3, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    tbl[6]  = mk(2'd1, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    tbl[7]  = mk(2'd2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    tbl[8]  = mk(2'd1, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    tbl[10] = mk(2'd0, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(2'd1, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(2'd2, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(2'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_outputs", {sum, cout, ovf, zero}, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Vector table, back-to-back at full throughput.
    foreach (tbl[i]) send(tbl[i], $sformatf("tbl%0d", i));
    drain();

`ifdef PIPE_ADDSUB_SAT_EN
    send(mk(2'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0), "sat_add_pos");
    send(mk(2'd1, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0), "sat_sub_neg");
    send(mk(2'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0), "wrap_add");
    send(mk(2'd1, 32'h8000_0000, 32'h1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0), "wrap_sub");
    send(mk(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0), "sat_zero");
    send(mk(2'd0, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b0), "sat_no_ovf");
    drain();
`endif

    // Latency across STAGES = 1, 2, 4 with the carry crossing slice boundaries.
    repeat (6) @(posedge clk);
    #1;
    lat1 = 0; lat2 = 0; lat4 = 0; res1 = '0; res4 = '0;
    eadc = '{32'h0001_0000, 1'b0, 1'b0, 1'b0};
    send(mk(2'd2, 32'h0000_FFFF, 32'h0, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0), "adc_lat");
    for (int n = 1; n <= 8; n++) begin
      if (u1_out_valid && lat1 == 0) begin lat1 = n; res1 = {u1_sum, u1_cout, u1_ovf, u1_zero}; end
      if (out_valid && lat2 == 0) lat2 = n;
      if (u4_out_valid && lat4 == 0) begin lat4 = n; res4 = {u4_sum, u4_cout, u4_ovf, u4_zero}; end
      @(posedge clk); #1;
    end
    check("latency_stages1", lat1, 1);
    check("latency_stages2", lat2, 2);
    check("latency_stages4", lat4, 4);
    check("adc_stages1", res1, eadc);
    check("adc_stages4", res4, eadc);
    check("ready_stages1", u1_in_ready, 1);
    check("ready_stages4", u4_in_ready, 1);
    drain();

    // Four back-to-back beats with a three-cycle stall after the first result.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++)
          send(mk(2'd0, 32'(i), 32'(i), 1'b0, 1'b0, 32'(2 * i), 1'b0, 1'b0, 1'b0), "stall_beat");
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
          @(negedge clk);
          seen = out_valid;
        end
        check("stall_first_valid", seen, 1);
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          check("stall_in_ready_low", in_ready, 0);
          check("stall_sum_held", sum, 32'd2);
          check("stall_out_valid_held", out_valid, 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight: they must never come out.
    out_ready = 1'b0;
    send(mk(2'd0, 32'd10, 32'd10, 1'b0, 1'b0, 32'd20, 1'b0, 1'b0, 1'b0), "flush_a");
    send(mk(2'd0, 32'd11, 32'd11, 1'b0, 1'b0, 32'd22, 1'b0, 1'b0, 1'b0), "flush_b");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1);
    check("flush_outputs_zero", {sum, cout, ovf, zero}, 0);
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      check("flush_no_valid", out_valid, 0);
      @(negedge clk);
    end
    check("flush_queue_empty", sbq.size(), 0);
    @(posedge clk); #1;

    // Random traffic with random back-pressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          vr.op  = 2'($urandom_range(0, 3));
          vr.a   = $urandom;
          vr.b   = (i % 5 == 0) ? ~vr.a : $urandom;
          vr.cin = 1'($urandom_range(0, 1));
`ifdef PIPE_ADDSUB_SAT_EN
          vr.sat = 1'($urandom_range(0, 1));
`else
          vr.sat = 1'b0;
`endif
          vr.exp = model(vr.op, vr.a, vr.b, vr.cin, vr.sat);
          send(vr, "rand");
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        drain();
      end
      begin
        for (int n = 0; n < 300; n++) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join_any
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
